// File: rtl/hazard_pkg.sv
// Shared types and constants for the parametrised pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [2:0] {
        NORMAL     = 3'd0,
        JUMP_FLUSH = 3'd1,
        BR_WAIT    = 3'd2,
        BR_TAKEN   = 3'd3,
        LOAD_STALL = 3'd4
    } hazard_state_e;

    localparam logic [1:0] ADDR_SEQ    = 2'b00;
    localparam logic [1:0] ADDR_JUMP   = 2'b01;
    localparam logic [1:0] ADDR_BRANCH = 2'b10;

    localparam int BR_MODE_STALL = 0;
    localparam int BR_MODE_PNT   = 1;

    typedef struct packed {
        logic       if_write;
        logic       pc_write;
        logic       bubble;
        logic [1:0] addr_sel;
    } hazard_ctl_t;

    function automatic hazard_ctl_t mk_ctl(input logic if_w, input logic pc_w,
                                           input logic bub, input logic [1:0] sel);
        hazard_ctl_t c;
        c.if_write = if_w;
        c.pc_write = pc_w;
        c.bubble   = bub;
        c.addr_sel = sel;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_param_if.sv
// Decode-side inputs and pipeline-control outputs of the hazard controller.
// Optional perf counters appear when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_param_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    import hazard_pkg::*;

    logic              jump;
    logic              branch;
    logic              alu_zero;
    logic              mem_read_ex;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              mem_wait;
    logic              if_write;
    logic              pc_write;
    logic              bubble;
    logic [1:0]        addr_sel;
    hazard_state_e     state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    modport master (
        output jump, branch, alu_zero, mem_read_ex, ex_rt, id_rs, id_rt,
               id_use_rs, id_use_rt, mem_wait,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cnt, flush_cnt,
`endif
        input  if_write, pc_write, bubble, addr_sel, state
    );

    modport slave (
        input  jump, branch, alu_zero, mem_read_ex, ex_rt, id_rs, id_rt,
               id_use_rs, id_use_rt, mem_wait,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cnt, flush_cnt,
`endif
        output if_write, pc_write, bubble, addr_sel, state
    );

endinterface

// File: rtl/hazard_load_detect.sv
// Combinational load-use comparator: the load in EX writes a register the ID instruction reads.
module hazard_load_detect #(
    parameter int REG_AW = 5
) (
    input  logic              mem_read_ex_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    output logic              load_hz_o
);

    // $0 is hard-wired, so a load into it never creates a dependency.
    assign load_hz_o = mem_read_ex_i && (ex_rt_i != '0) &&
                       ((id_use_rs_i && (ex_rt_i == id_rs_i)) ||
                        (id_use_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_ctrl_param.sv
// Pipeline hazard controller: load-use stalls, jump/branch flushes, memory freeze.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush counters.
module hazard_ctrl_param
    import hazard_pkg::*;
#(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BR_MODE           = 0,
    parameter int CNT_W             = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_param_if.slave bus
);

    localparam int LS_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;

    hazard_state_e   state_q, state_d;
    logic [LS_W-1:0] cnt_q, cnt_d;
    hazard_ctl_t     ctl;
    logic            load_hz;
    logic            run_normal;

    hazard_load_detect #(.REG_AW(REG_AW)) u_load_detect (
        .mem_read_ex_i (bus.mem_read_ex),
        .ex_rt_i       (bus.ex_rt),
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .id_use_rs_i   (bus.id_use_rs),
        .id_use_rt_i   (bus.id_use_rt),
        .load_hz_o     (load_hz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ctl        = mk_ctl(1'b1, 1'b1, 1'b0, ADDR_SEQ);
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_normal = 1'b0;
        if (bus.mem_wait) begin
            ctl = mk_ctl(1'b0, 1'b0, 1'b0, ADDR_SEQ);
        end else begin
            case (state_q)
                NORMAL: run_normal = 1'b1;
                JUMP_FLUSH, BR_TAKEN: begin
                    ctl     = mk_ctl(1'b1, 1'b1, 1'b1, ADDR_SEQ);
                    state_d = NORMAL;
                end
                LOAD_STALL: begin
                    ctl   = mk_ctl(1'b0, 1'b0, 1'b1, ADDR_SEQ);
                    cnt_d = cnt_q - LS_W'(1);
                    if (cnt_q <= LS_W'(1)) state_d = NORMAL;
                end
                BR_WAIT: begin
                    if (bus.alu_zero) begin
                        ctl     = mk_ctl(1'b0, 1'b1, 1'b1, ADDR_BRANCH);
                        state_d = BR_TAKEN;
                    end else if (BR_MODE == BR_MODE_STALL) begin
                        ctl     = mk_ctl(1'b1, 1'b1, 1'b1, ADDR_SEQ);
                        state_d = NORMAL;
                    end else begin
                        // Fall-through was already fetched: ID holds a fresh instruction.
                        run_normal = 1'b1;
                    end
                end
                default: begin
                    ctl     = mk_ctl(1'b0, 1'b0, 1'b1, ADDR_SEQ);
                    state_d = NORMAL;
                end
            endcase
            if (run_normal) begin
                state_d = NORMAL;
                if (bus.jump) begin
                    ctl     = mk_ctl(1'b0, 1'b1, 1'b0, ADDR_JUMP);
                    state_d = JUMP_FLUSH;
                end else if (load_hz) begin
                    ctl = mk_ctl(1'b0, 1'b0, 1'b1, ADDR_SEQ);
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = LS_W'(LOAD_STALL_CYCLES - 1);
                    end
                end else if (bus.branch) begin
                    if (BR_MODE == BR_MODE_PNT) ctl = mk_ctl(1'b1, 1'b1, 1'b0, ADDR_SEQ);
                    else                        ctl = mk_ctl(1'b0, 1'b0, 1'b0, ADDR_SEQ);
                    state_d = BR_WAIT;
                end
            end
        end
        if (reset) ctl = mk_ctl(1'b0, 1'b0, 1'b1, ADDR_SEQ);
    end

    assign bus.if_write = ctl.if_write;
    assign bus.pc_write = ctl.pc_write;
    assign bus.bubble   = ctl.bubble;
    assign bus.addr_sel = ctl.addr_sel;
    assign bus.state    = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ctl.pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (((state_q == JUMP_FLUSH) || (state_q == BR_TAKEN)) && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: two instances (stall-until-resolve and predict-not-taken)
// checked every cycle against a slot-schedule model, plus literal expectations.
module tb_hazard_ctrl_param;
  import hazard_pkg::*;

  localparam int AW   = 5;
  localparam int LSC0 = 2;
  localparam int LSC1 = 3;
  localparam int CW0  = 16;
  localparam int CW1  = 4;

  localparam int S_FLUSH   = 0;
  localparam int S_STALL   = 1;
  localparam int S_RESOLVE = 2;

  logic clk = 1'b0;
  logic reset;
  logic jump, branch, alu_zero, mem_read_ex, id_use_rs, id_use_rt, mem_wait;
  logic [AW-1:0] ex_rt, id_rs, id_rt;

  int checks = 0;
  int failures = 0;
  int sched[2][$];
`ifdef HAZARD_PERF_CNT_EN
  int stall_m[2];
  int flush_m[2];
`endif

  hazard_ctrl_param_if #(.REG_AW(AW), .CNT_W(CW0)) bus0 ();
  hazard_ctrl_param_if #(.REG_AW(AW), .CNT_W(CW1)) bus1 ();

  assign bus0.jump = jump;               assign bus1.jump = jump;
  assign bus0.branch = branch;           assign bus1.branch = branch;
  assign bus0.alu_zero = alu_zero;       assign bus1.alu_zero = alu_zero;
  assign bus0.mem_read_ex = mem_read_ex; assign bus1.mem_read_ex = mem_read_ex;
  assign bus0.ex_rt = ex_rt;             assign bus1.ex_rt = ex_rt;
  assign bus0.id_rs = id_rs;             assign bus1.id_rs = id_rs;
  assign bus0.id_rt = id_rt;             assign bus1.id_rt = id_rt;
  assign bus0.id_use_rs = id_use_rs;     assign bus1.id_use_rs = id_use_rs;
  assign bus0.id_use_rt = id_use_rt;     assign bus1.id_use_rt = id_use_rt;
  assign bus0.mem_wait = mem_wait;       assign bus1.mem_wait = mem_wait;

  hazard_ctrl_param #(.REG_AW(AW), .LOAD_STALL_CYCLES(LSC0), .BR_MODE(0), .CNT_W(CW0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  hazard_ctrl_param #(.REG_AW(AW), .LOAD_STALL_CYCLES(LSC1), .BR_MODE(1), .CNT_W(CW1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [4:0] act(input int m);
    if (m == 0) return {bus0.if_write, bus0.pc_write, bus0.bubble, bus0.addr_sel};
    return {bus1.if_write, bus1.pc_write, bus1.bubble, bus1.addr_sel};
  endfunction

  task automatic cmp(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, a, e, $time);
    end
  endtask

  // behavioural model: ID-visible instructions follow the plain rules; earlier
  // decisions leave a queue of forced slots (flush, stall, branch resolve).
  function automatic bit hz();
    return mem_read_ex && (ex_rt != 0) &&
           ((id_use_rs && ex_rt == id_rs) || (id_use_rt && ex_rt == id_rt));
  endfunction

  task automatic free_eval(input int m, output logic [4:0] e);
    int lsc;
    lsc = (m == 0) ? LSC0 : LSC1;
    if (jump) begin
      e = 5'b01001;
      sched[m].push_back(S_FLUSH);
    end else if (hz()) begin
      e = 5'b00100;
      for (int i = 1; i < lsc; i++) sched[m].push_back(S_STALL);
    end else if (branch) begin
      e = (m == 0) ? 5'b00000 : 5'b11000;
      sched[m].push_back(S_RESOLVE);
    end else begin
      e = 5'b11000;
    end
  endtask

  task automatic model_cycle(input int m, output logic [4:0] e);
    int k;
    bit in_flush;
    in_flush = (sched[m].size() > 0) && (sched[m][0] == S_FLUSH);
    if (reset) begin
      e = 5'b00100;
      sched[m].delete();
    end else if (mem_wait) begin
      e = 5'b00000;
    end else if (sched[m].size() == 0) begin
      free_eval(m, e);
    end else begin
      k = sched[m].pop_front();
      if (k == S_FLUSH) e = 5'b11100;
      else if (k == S_STALL) e = 5'b00100;
      else if (alu_zero) begin
        e = 5'b01110;
        sched[m].push_back(S_FLUSH);
      end else if (m == 0) e = 5'b11100;
      else free_eval(m, e);
    end
`ifdef HAZARD_PERF_CNT_EN
    if (!reset) begin
      int mx;
      mx = (m == 0) ? (2 ** CW0) - 1 : (2 ** CW1) - 1;
      if (!e[3] && stall_m[m] < mx) stall_m[m]++;
      if (in_flush && flush_m[m] < mx) flush_m[m]++;
    end
`else
    if (in_flush) k = 0;
`endif
  endtask

  // scoreboard compare, once per cycle at the falling edge
  task automatic check_all();
    logic [4:0] e0, e1;
`ifdef HAZARD_PERF_CNT_EN
    if (reset) begin
      stall_m[0] = 0; stall_m[1] = 0; flush_m[0] = 0; flush_m[1] = 0;
    end
    cmp("stall_cnt0", int'(bus0.stall_cnt), stall_m[0]);
    cmp("flush_cnt0", int'(bus0.flush_cnt), flush_m[0]);
    cmp("stall_cnt1", int'(bus1.stall_cnt), stall_m[1]);
    cmp("flush_cnt1", int'(bus1.flush_cnt), flush_m[1]);
`endif
    model_cycle(0, e0);
    model_cycle(1, e1);
    cmp("model_ctl0", int'(act(0)), int'(e0));
    cmp("model_ctl1", int'(act(1)), int'(e1));
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [4:0] e0, input logic [4:0] e1);
    #1;
    cmp({name, "_m0"}, int'(act(0)), int'(e0));
    cmp({name, "_m1"}, int'(act(1)), int'(e1));
  endtask

  // driver tasks
  task automatic idle();
    jump = 0; branch = 0; alu_zero = 0; mem_read_ex = 0; mem_wait = 0;
    ex_rt = '0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
  endtask

  task automatic load_use_rs3();
    mem_read_ex = 1; ex_rt = 5'd3; id_rs = 5'd3; id_use_rs = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    lit("reset_out", 5'b00100, 5'b00100);
    cyc();
    reset = 0;

    lit("idle", 5'b11000, 5'b11000); cyc();

    load_use_rs3();
    lit("ld_hz", 5'b00100, 5'b00100); cyc();
    idle();
    lit("ld_stall1", 5'b00100, 5'b00100); cyc();
    lit("ld_stall2", 5'b11000, 5'b00100); cyc();
    lit("ld_done", 5'b11000, 5'b11000); cyc();

    mem_read_ex = 1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1;
    lit("ld_r0", 5'b11000, 5'b11000); cyc();
    idle();

    mem_read_ex = 1; ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_use_rs = 1; id_use_rt = 0;
    lit("unused_rt", 5'b11000, 5'b11000); cyc();
    id_use_rt = 1;
    lit("used_rt", 5'b00100, 5'b00100); cyc();
    idle(); cyc(); cyc();

    branch = 1;
    lit("br_issue", 5'b00000, 5'b11000); cyc();
    branch = 0; alu_zero = 1;
    lit("br_taken", 5'b01110, 5'b01110); cyc();
    alu_zero = 0;
    lit("br_flush", 5'b11100, 5'b11100); cyc();
    lit("br_done", 5'b11000, 5'b11000); cyc();

    branch = 1; cyc();
    branch = 0;
    lit("br_not_taken", 5'b11100, 5'b11000); cyc(); cyc();

    jump = 1; branch = 1; load_use_rs3();
    lit("jmp_wins", 5'b01001, 5'b01001); cyc();
    idle();
    lit("jmp_flush", 5'b11100, 5'b11100); cyc();

    branch = 1; cyc();
    branch = 0; alu_zero = 1; mem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      lit("mw_freeze", 5'b00000, 5'b00000); cyc();
    end
    mem_wait = 0;
    lit("mw_resume", 5'b01110, 5'b01110); cyc();
    alu_zero = 0;
    lit("mw_flush", 5'b11100, 5'b11100); cyc();

    load_use_rs3(); cyc();
    idle();
    #1 reset = 1;
    lit("rst_async", 5'b00100, 5'b00100);
`ifdef HAZARD_PERF_CNT_EN
    cmp("rst_stall_cnt0", int'(bus0.stall_cnt), 0);
    cmp("rst_flush_cnt1", int'(bus1.flush_cnt), 0);
`endif
    cyc();
    reset = 0;
    lit("rst_release", 5'b11000, 5'b11000); cyc();

    // randomized stimulus
    for (int n = 0; n < 3000; n++) begin
      jump        = ($urandom_range(0, 7) == 0);
      branch      = ($urandom_range(0, 5) == 0);
      alu_zero    = $urandom_range(0, 1) == 1;
      mem_read_ex = ($urandom_range(0, 2) == 0);
      ex_rt       = AW'($urandom_range(0, 3));
      id_rs       = AW'($urandom_range(0, 3));
      id_rt       = AW'($urandom_range(0, 3));
      id_use_rs   = $urandom_range(0, 1) == 1;
      id_use_rt   = $urandom_range(0, 1) == 1;
      mem_wait    = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 0;
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
